// File: rtl/fetch_pkg.sv
// Shared widths, state encoding and the decoded-instruction field bundle for the fetch controller.
package fetch_pkg;
    localparam int ADDR_W = 7;
    localparam int STEP   = 4;
    localparam int REG_W  = 5;
    localparam int IMM_W  = 12;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [IMM_W-1:0] imm;
    } instr_t;
endpackage

// File: rtl/fetch_outreg.sv
// Output register with valid/ready: load captures a new instruction, flush drops it, otherwise hold.
// Latency 1 cycle from load; when valid and not ready the contents stay frozen.
module fetch_outreg import fetch_pkg::*; #(
    parameter int AW = ADDR_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          flush,
    input  logic          ready,
    input  logic [AW-1:0] in_adrs,
    input  instr_t        in_instr,
    output logic          valid,
    output logic [AW-1:0] out_adrs,
    output instr_t        out_instr
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid     <= 1'b0;
            out_adrs  <= '0;
            out_instr <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (load) begin
            valid     <= 1'b1;
            out_adrs  <= in_adrs;
            out_instr <= in_instr;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end
endmodule

// File: rtl/fetch_ctrl.sv
// Sequential instruction fetch from startAdrs to stopAdrs with redirect and output stall.
// Latency 1 cycle from readAdrs to out*; pc holds while the output is valid and not ready.
module fetch_ctrl #(
    parameter int ADDR_W = fetch_pkg::ADDR_W,
    parameter int STEP   = fetch_pkg::STEP
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAdrs,
    input  logic [ADDR_W-1:0] stopAdrs,
    input  logic              redirValid,
    input  logic [ADDR_W-1:0] redirAdrs,
    output logic [ADDR_W-1:0] readAdrs,
    input  logic [4:0]        memRd,
    input  logic [4:0]        memRs1,
    input  logic [4:0]        memRs2,
    input  logic [11:0]       memImm,
    output logic              outValid,
    input  logic              outReady,
    output logic [ADDR_W-1:0] outAdrs,
    output logic [4:0]        outRd,
    output logic [4:0]        outRs1,
    output logic [4:0]        outRs2,
    output logic [11:0]       outImm,
    output logic              busy,
    output logic              done
);
    import fetch_pkg::*;

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

    logic [1:0]        state;
    logic [ADDR_W-1:0] pc;
    logic              running;
    logic              load;
    logic              flush;
    instr_t            mem_instr;
    instr_t            out_instr;

    assign running = (state == ST_RUN);
    // Redirect pre-empts any load in the same cycle.
    assign load    = running && (!outValid || outReady) && !redirValid;
    assign flush   = running && redirValid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        pc    <= startAdrs & ALIGN_MASK;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (redirValid) begin
                        pc <= redirAdrs & ALIGN_MASK;
                    end else if (load) begin
                        if (pc == stopAdrs) state <= ST_DONE;
                        else                pc    <= pc + ADDR_W'(STEP);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign mem_instr = '{rd: memRd, rs1: memRs1, rs2: memRs2, imm: memImm};

    fetch_outreg #(.AW(ADDR_W)) u_outreg (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .flush     (flush),
        .ready     (outReady),
        .in_adrs   (pc),
        .in_instr  (mem_instr),
        .valid     (outValid),
        .out_adrs  (outAdrs),
        .out_instr (out_instr)
    );

    assign readAdrs = pc;
    assign outRd    = out_instr.rd;
    assign outRs1   = out_instr.rs1;
    assign outRs2   = out_instr.rs2;
    assign outImm   = out_instr.imm;
    assign busy     = running;
    assign done     = (state == ST_DONE) && !outValid;
endmodule
